// File: rtl/path_count_if.sv
// Run-control and adjacency-ROM signals of path_count_engine, bundled as one interface.
// The engine connects through the slave modport; the run controller / ROM side uses master.
interface path_count_if #(
    parameter int NODE_W = 10,
    parameter int CNT_W  = 5,
    parameter int ACC_W  = 48
);
    logic              start;
    logic [NODE_W-1:0] start_node_idx;
    logic [NODE_W-1:0] end_node_idx;
    logic [NODE_W-1:0] node_idx_reg;
    logic [CNT_W-1:0]  edge_sel;
    logic [NODE_W-1:0] next_node_idx;
    logic [CNT_W-1:0]  next_node_counter;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  path_count;
    logic              overflow;

    modport master (
        output start, start_node_idx, end_node_idx, next_node_idx, next_node_counter,
        input  node_idx_reg, edge_sel, busy, done, path_count, overflow
    );

    modport slave (
        input  start, start_node_idx, end_node_idx, next_node_idx, next_node_counter,
        output node_idx_reg, edge_sel, busy, done, path_count, overflow
    );
endinterface

// File: rtl/path_count_engine.sv
// Counts directed paths start->end in a DAG held in an external adjacency ROM, one edge per cycle.
// Optional macro PATHCNT_MERGE_EN: CAM-merge successors into pending queue entries instead of pushing.
module path_count_engine #(
    parameter int PARAM_NODE_IDX_WIDTH  = 10,
    parameter int PARAM_COUNTER_WIDTH   = 5,
    parameter int PARAM_ACCUM_VAL_WIDTH = 48,
    parameter int PARAM_FIFO_DEPTH      = 32
) (
    input logic        clk,
    input logic        rst_n,
    path_count_if.slave pc
);
    localparam int NW    = PARAM_NODE_IDX_WIDTH;
    localparam int CW    = PARAM_COUNTER_WIDTH;
    localparam int AW    = PARAM_ACCUM_VAL_WIDTH;
    localparam int PTR_W = $clog2(PARAM_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_SCAN, S_DONE} state_t;

    state_t                state_q;
    logic [PARAM_FIFO_DEPTH-1:0] q_vld_q;
    logic [NW-1:0]         q_idx_q [PARAM_FIFO_DEPTH];
    logic [AW-1:0]         q_cnt_q [PARAM_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]         node_idx_q, end_idx_q;
    logic [CW-1:0]         edge_sel_q;
    logic [AW-1:0]         cur_count_q, end_accum_q, path_count_q;
    logic                  busy_q, done_q, overflow_q;

    logic                  q_full, q_empty, merge_hit, scan_last, is_end;
    logic                  accept, seed_push, take_pop, take_end, take_merge, take_push, take_full;
    logic [PTR_W-1:0]      hit_ptr;
    logic [AW:0]           end_sum_d, merge_sum_d;

    // Modulo-2^AW add; the extra MSB is the carry-out that flags overflow.
    function automatic logic [AW:0] add_carry(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    always_comb begin
        q_full    = (wr_ptr_q == rd_ptr_q) && q_vld_q[wr_ptr_q];
        q_empty   = (wr_ptr_q == rd_ptr_q) && !q_vld_q[wr_ptr_q];
        merge_hit = 1'b0;
        hit_ptr   = '0;
`ifdef PATHCNT_MERGE_EN
        for (int i = 0; i < PARAM_FIFO_DEPTH; i++) begin
            if (q_vld_q[i] && (q_idx_q[i] == pc.next_node_idx)) begin
                merge_hit = 1'b1;
                hit_ptr   = PTR_W'(i);
            end
        end
`endif
        scan_last   = (pc.edge_sel == pc.next_node_counter);
        is_end      = (pc.next_node_idx == end_idx_q);
        accept      = (state_q == S_IDLE) && pc.start;
        seed_push   = accept && (pc.start_node_idx != pc.end_node_idx);
        take_pop    = (state_q == S_POP) && !q_empty;
        take_end    = (state_q == S_SCAN) && !scan_last && is_end;
        take_merge  = (state_q == S_SCAN) && !scan_last && !is_end && merge_hit;
        take_push   = (state_q == S_SCAN) && !scan_last && !is_end && !merge_hit && !q_full;
        take_full   = (state_q == S_SCAN) && !scan_last && !is_end && !merge_hit && q_full;
        end_sum_d   = add_carry(end_accum_q, cur_count_q);
        merge_sum_d = add_carry(q_cnt_q[hit_ptr], cur_count_q);
    end

    // Control stage: FSM, queue valid bits/pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            q_vld_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            node_idx_q   <= '0;
            edge_sel_q   <= '0;
            path_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                        if (seed_push) begin
                            q_vld_q[wr_ptr_q] <= 1'b1;
                            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
                            state_q           <= S_POP;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_POP: begin
                    if (q_empty) begin
                        state_q <= S_DONE;
                    end else begin
                        node_idx_q        <= q_idx_q[rd_ptr_q];
                        q_vld_q[rd_ptr_q] <= 1'b0;
                        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
                        edge_sel_q        <= '0;
                        state_q           <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_last) begin
                        state_q <= S_POP;
                    end else if (take_full) begin
                        overflow_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        edge_sel_q <= edge_sel_q + CW'(1);
                        if ((take_end && end_sum_d[AW]) || (take_merge && merge_sum_d[AW]))
                            overflow_q <= 1'b1;
                        if (take_push) begin
                            q_vld_q[wr_ptr_q] <= 1'b1;
                            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    path_count_q <= end_accum_q;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Data stage: queue payload, current count and end accumulator carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            end_idx_q   <= pc.end_node_idx;
            end_accum_q <= seed_push ? '0 : AW'(1);
        end
        if (seed_push) begin
            q_idx_q[wr_ptr_q] <= pc.start_node_idx;
            q_cnt_q[wr_ptr_q] <= AW'(1);
        end
        if (take_pop)
            cur_count_q <= q_cnt_q[rd_ptr_q];
        if (take_end)
            end_accum_q <= end_sum_d[AW-1:0];
        if (take_merge)
            q_cnt_q[hit_ptr] <= merge_sum_d[AW-1:0];
        if (take_push) begin
            q_idx_q[wr_ptr_q] <= pc.next_node_idx;
            q_cnt_q[wr_ptr_q] <= cur_count_q;
        end
    end

    assign pc.node_idx_reg = node_idx_q;
    assign pc.edge_sel     = edge_sel_q;
    assign pc.busy         = busy_q;
    assign pc.done         = done_q;
    assign pc.path_count   = path_count_q;
    assign pc.overflow     = overflow_q;
endmodule
